// File: rtl/vga_text_writer.sv
// Byte stream to vga text writes: tracks an 80x24 cursor, handles CR/LF/BS/FF; one-cycle write latency.
// Backpressure: in_ready drops for the whole screen clear (reset or FF), otherwise one byte per cycle.
module vga_text_writer #(
  parameter int         COLS       = 80,
  parameter int         ROWS       = 24,
  parameter logic [7:0] BLANK_CHAR = 8'h00
) (
  input  logic        CLK,
  input  logic        reset_n,
  input  logic [7:0]  in_char,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  write_char,
  output logic [10:0] write_char_pos,
  output logic        write_char_strobe,
  output logic [10:0] cursor_pos,
  output logic        busy
);

  localparam int CELLS = COLS * ROWS;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] COL_MAX       = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX       = RW'(ROWS - 1);
  // Clear counter is one bit wider than a position so a full 2048-cell screen can still signal done.
  localparam logic [11:0]   CLR_END       = 12'(CELLS);
  localparam logic [10:0]   LAST_ROW_BASE = 11'((ROWS - 1) * COLS);
  localparam logic [10:0]   COLS_W        = 11'(COLS);

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t        state, state_nxt;
  logic [11:0]   clr_cnt, clr_nxt;
  logic [CW-1:0] col, col_nxt;
  logic [RW-1:0] row, row_nxt;
  logic [10:0]   cur_nxt;
  logic [7:0]    chr_nxt;
  logic [10:0]   pos_nxt;
  logic          stb_nxt;

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state             <= CLEAR;
      clr_cnt           <= '0;
      col               <= '0;
      row               <= '0;
      cursor_pos        <= '0;
      write_char        <= BLANK_CHAR;
      write_char_pos    <= '0;
      write_char_strobe <= 1'b0;
      in_ready          <= 1'b0;
      busy              <= 1'b1;
    end else begin
      state             <= state_nxt;
      clr_cnt           <= clr_nxt;
      col               <= col_nxt;
      row               <= row_nxt;
      cursor_pos        <= cur_nxt;
      write_char        <= chr_nxt;
      write_char_pos    <= pos_nxt;
      write_char_strobe <= stb_nxt;
      in_ready          <= (state_nxt == IDLE);
      busy              <= (state_nxt == CLEAR);
    end
  end

  always_comb begin
    state_nxt = state;
    clr_nxt   = clr_cnt;
    col_nxt   = col;
    row_nxt   = row;
    cur_nxt   = cursor_pos;
    chr_nxt   = write_char;
    pos_nxt   = write_char_pos;
    stb_nxt   = 1'b0;

    case (state)
      CLEAR: begin
        if (clr_cnt == CLR_END) begin
          state_nxt = IDLE;
          col_nxt   = '0;
          row_nxt   = '0;
          cur_nxt   = '0;
        end else begin
          stb_nxt = 1'b1;
          chr_nxt = BLANK_CHAR;
          pos_nxt = clr_cnt[10:0];
          clr_nxt = clr_cnt + 12'd1;
        end
      end

      IDLE: begin
        if (in_valid && in_ready) begin
          case (in_char)
            8'h0D: begin
              col_nxt = '0;
              cur_nxt = cursor_pos - 11'(col);
            end
            8'h0A: begin
              if (row == ROW_MAX) begin
                row_nxt = '0;
                cur_nxt = cursor_pos - LAST_ROW_BASE;
              end else begin
                row_nxt = row + 1'b1;
                cur_nxt = cursor_pos + COLS_W;
              end
            end
            8'h08: begin
              if (col != '0) begin
                col_nxt = col - 1'b1;
                cur_nxt = cursor_pos - 11'd1;
                stb_nxt = 1'b1;
                chr_nxt = BLANK_CHAR;
                pos_nxt = cursor_pos - 11'd1;
              end
            end
            // Cell 0 is blanked on the accepting edge so the clear lines up with a normal write.
            8'h0C: begin
              state_nxt = CLEAR;
              clr_nxt   = 12'd1;
              stb_nxt   = 1'b1;
              chr_nxt   = BLANK_CHAR;
              pos_nxt   = '0;
            end
            default: begin
              stb_nxt = 1'b1;
              chr_nxt = in_char;
              pos_nxt = cursor_pos;
              if (col == COL_MAX) begin
                col_nxt = '0;
                if (row == ROW_MAX) begin
                  row_nxt = '0;
                  cur_nxt = '0;
                end else begin
                  row_nxt = row + 1'b1;
                  cur_nxt = cursor_pos + 11'd1;
                end
              end else begin
                col_nxt = col + 1'b1;
                cur_nxt = cursor_pos + 11'd1;
              end
            end
          endcase
        end
      end
    endcase
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Randomized and directed bench for vga_text_writer against a row/col screen model.
module tb_vga_text_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 24;
  localparam int CELLS = COLS * ROWS;
  localparam logic [7:0] BLANK = 8'h00;

  logic        CLK = 1'b0;
  logic        reset_n;
  logic [7:0]  in_char;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  write_char;
  logic [10:0] write_char_pos;
  logic        write_char_strobe;
  logic [10:0] cursor_pos;
  logic        busy;

  vga_text_writer dut (
    .CLK               (CLK),
    .reset_n           (reset_n),
    .in_char           (in_char),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .write_char        (write_char),
    .write_char_pos    (write_char_pos),
    .write_char_strobe (write_char_strobe),
    .cursor_pos        (cursor_pos),
    .busy              (busy)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Reference model: cursor as row/col, a clear as a countdown of blank writes.
  int   mrow, mcol;
  bit   clr_mode;
  int   clr_n;
  bit   exp_stb, exp_ready, exp_busy;
  int   exp_chr, exp_pos, exp_cursor;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("strobe", 32'(write_char_strobe), 32'(exp_stb));
    if (exp_stb) begin
      chk("char", 32'(write_char), exp_chr);
      chk("pos", 32'(write_char_pos), exp_pos);
    end
    chk("ready", 32'(in_ready), 32'(exp_ready));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("cursor", 32'(cursor_pos), exp_cursor);
  endtask

  task automatic model_reset();
    clr_mode   = 1'b1;
    clr_n      = 0;
    mrow       = 0;
    mcol       = 0;
    exp_stb    = 1'b0;
    exp_ready  = 1'b0;
    exp_busy   = 1'b1;
    exp_cursor = 0;
    exp_chr    = 0;
    exp_pos    = 0;
  endtask

  task automatic model_edge(input bit acc, input logic [7:0] ch);
    exp_stb = 1'b0;
    if (clr_mode) begin
      if (clr_n < CELLS) begin
        exp_stb = 1'b1; exp_chr = BLANK; exp_pos = clr_n; clr_n++;
      end else begin
        clr_mode = 1'b0; mrow = 0; mcol = 0; exp_cursor = 0;
      end
    end else if (acc) begin
      case (ch)
        8'h0D: mcol = 0;
        8'h0A: mrow = (mrow + 1) % ROWS;
        8'h08: if (mcol > 0) begin
          mcol--;
          exp_stb = 1'b1; exp_chr = BLANK; exp_pos = mrow * COLS + mcol;
        end
        8'h0C: begin
          clr_mode = 1'b1; clr_n = 1;
          exp_stb = 1'b1; exp_chr = BLANK; exp_pos = 0;
        end
        default: begin
          exp_stb = 1'b1; exp_chr = ch; exp_pos = mrow * COLS + mcol;
          mcol++;
          if (mcol == COLS) begin
            mcol = 0;
            mrow = (mrow + 1) % ROWS;
          end
        end
      endcase
      if (!clr_mode) exp_cursor = mrow * COLS + mcol;
    end
    exp_ready = !clr_mode;
    exp_busy  = clr_mode;
  endtask

  // Called at a negedge: drive, let one rising edge pass, then check at the following negedge.
  task automatic cyc(input bit v, input logic [7:0] ch, output bit acc);
    in_valid = v;
    in_char  = ch;
    acc = v && exp_ready;
    @(posedge CLK);
    model_edge(acc, ch);
    @(negedge CLK);
    check_all();
  endtask

  task automatic send(input logic [7:0] ch);
    bit acc = 1'b0;
    for (int i = 0; i < 4000 && !acc; i++) cyc(1'b1, ch, acc);
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, acc);
  endtask

  task automatic wait_ready();
    bit acc;
    for (int i = 0; i < 4000 && !exp_ready; i++) cyc(1'b0, 8'h00, acc);
  endtask

  function automatic logic [7:0] rnd_print();
    logic [7:0] c;
    do c = 8'($urandom_range(0, 255));
    while (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D);
    return c;
  endfunction

  initial begin
    bit acc;
    int r;
    logic [7:0] ch;

    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_char  = 8'h00;
    model_reset();
    @(negedge CLK);
    @(negedge CLK);
    check_all();
    chk("rst_char", 32'(write_char), 32'(BLANK));
    chk("rst_pos", 32'(write_char_pos), 32'd0);

    // Power-up clear: 1920 blank writes then ready.
    reset_n = 1'b1;
    wait_ready();
    idle(2);

    // Back-to-back stream.
    send(8'h01); send(8'h02); send(8'h03);
    idle(1);

    // Row wrap, CR/LF, full-screen wrap.
    send(8'h0D);
    for (int i = 0; i < 79; i++) send(rnd_print());
    send(8'h04);
    send(8'h0D); send(8'h0A);
    for (int i = 0; i < 21; i++) send(8'h0A);
    for (int i = 0; i < 79; i++) send(rnd_print());
    send(8'h41);
    idle(1);

    // Backspace at col 5 and at col 0.
    send(8'h0A); send(8'h0A);
    for (int i = 0; i < 5; i++) send(rnd_print());
    send(8'h08);
    send(8'h0D);
    send(8'h08);
    idle(1);

    // FF with the next byte held valid throughout the clear.
    send(8'h0C);
    send(8'h02);
    idle(2);

    // Random traffic mixing printables and control codes.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 199);
      if (r < 140)      ch = rnd_print();
      else if (r < 155) ch = 8'h0D;
      else if (r < 172) ch = 8'h0A;
      else if (r < 198) ch = 8'h08;
      else              ch = 8'h0C;
      cyc($urandom_range(0, 3) != 0, ch, acc);
    end
    wait_ready();

    // Reset in the middle of a clear.
    send(8'h0C);
    for (int i = 0; i < 4000 && !(exp_stb && exp_pos == 700); i++) cyc(1'b0, 8'h00, acc);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("midrst_char", 32'(write_char), 32'(BLANK));
    chk("midrst_pos", 32'(write_char_pos), 32'd0);
    @(negedge CLK);
    check_all();
    reset_n = 1'b1;
    wait_ready();
    send(8'h37);
    idle(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_text_writer.md
# vga_text_writer

Upstream feeder for the `vga` text-mode core: accepts a byte stream over a valid/ready handshake and turns it into `write_char`/`write_char_pos`/`write_char_strobe` writes. Maintains a text cursor over the 80x24 character grid and interprets a small set of control codes (CR, LF, BS, FF). Sits between the CPU/UART byte source and `vga`, replacing free-running test-pattern writers.

## Interface
- `COLS`, 80, characters per row
- `ROWS`, 24, rows per screen; `COLS*ROWS` must be ≤ 2048
- `BLANK_CHAR`, 8'h00, glyph code written for clears and backspace
- `CLK`  in  1  system clock, all logic on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_char`  in  8  byte to print or control code
- `in_valid`  in  1  `in_char` valid
- `in_ready`  out  1  block accepts `in_char` this cycle
- `write_char`  out  8  glyph code to `vga`
- `write_char_pos`  out  11  linear cell address, row*COLS+col
- `write_char_strobe`  out  1  single-cycle write pulse to `vga`
- `cursor_pos`  out  11  current cursor, linear address
- `busy`  out  1  high while a screen clear is in progress

## Operation
- Decided: one clock `CLK`; reset `reset_n` is asynchronous and active-low.
- State: `col` (0..COLS-1) and `row` (0..ROWS-1) counters, plus registered linear `cursor_pos`, updated incrementally (no multiply or divide).
- FSM states: `CLEAR`, `IDLE`.
- Reset values: `write_char`=BLANK_CHAR, `write_char_pos`=0, `write_char_strobe`=0, `in_ready`=0, `cursor_pos`=0, col=row=0, `busy`=1, state=`CLEAR` with clear address 0.
- A transfer occurs only on a `CLK` edge with `in_valid && in_ready`. `in_ready` = (state==`IDLE`), registered.
- IDLE, printable byte (anything except 0x08/0x0A/0x0C/0x0D):
  - Write `in_char` at the cursor.
  - Advance col.
  - If col==COLS-1: col←0 and advance row.
  - If row==ROWS-1 as well: row←0, giving linear wrap 1919→0.
- 0x0D CR: col←0; no write.
- 0x0A LF: row←row+1, or 0 if row==ROWS-1; col unchanged; no write.
- 0x08 BS:
  - If col>0: col←col-1 and write BLANK_CHAR at the new position.
  - If col==0: no-op, with no write and no cursor change.
- 0x0C FF:
  - Enter `CLEAR`.
  - Write BLANK_CHAR at addresses 0..COLS*ROWS-1, one per cycle, ascending.
  - Then col=row=0 and return to `IDLE`.
- `CLEAR` after reset behaves identically, so the screen is blanked at power-up.
- `in_valid` with `in_ready` low is ignored; the source must hold the byte.
- Reset asserted mid-clear or mid-write aborts immediately. On release the clear restarts from address 0.

## Timing
- Throughput in `IDLE`: one byte per cycle; `in_ready` stays high across back-to-back transfers.
- Write latency: a byte accepted at edge T produces `write_char_strobe`=1 for exactly the cycle after T. `write_char` and `write_char_pos` are valid in that same cycle.
- `cursor_pos` reflects the post-byte cursor in the cycle after acceptance.
- `write_char_strobe` is 0 in every cycle without a write. CR, LF, no-op BS and ignored cycles produce no strobe.
- FF accepted at edge T:
  - `in_ready` is low from T+1.
  - Strobes occur in cycles T+1..T+COLS*ROWS (1920 cycles).
  - `busy` is high for the same window.
  - `in_ready` and `cursor_pos`=0 are restored in cycle T+COLS*ROWS+1.
- After reset release: clear strobes occupy the first 1920 cycles, and `in_ready` rises in cycle 1921.
- Position arithmetic is 11-bit unsigned. `write_char_pos` never exceeds COLS*ROWS-1.

## Test plan
- Reset release -> 1920 consecutive strobes with `write_char`=0x00 at pos 0..1919, then `in_ready`=1, `busy`=0, `cursor_pos`=0.
- Stream 0x01,0x02,0x03 back-to-back after init -> strobes on three consecutive cycles at pos 0,1,2 with chars 1,2,3; `in_ready` never drops; `cursor_pos`=3.
- 79 printables, then 0x04 -> last write at pos 79, `cursor_pos`=80; then 0x0D 0x0A -> `cursor_pos`=80 then 160 with no strobes; at row 23 col 79 a printable -> write at 1919, `cursor_pos` wraps to 0.
- Cursor at col 5 row 2 (pos 165), send 0x08 -> strobe with char 0x00 at pos 164, `cursor_pos`=164; at col 0, 0x08 -> no strobe, cursor unchanged.
- 0x0C with `in_valid` held high and a following byte 0x02 -> 1920 blank strobes, `busy` high; 0x02 is accepted only after the clear and written at pos 0.
- `reset_n` pulsed low during a clear at address 700 -> outputs return to reset values immediately; the clear restarts at pos 0 and completes all 1920 writes.
